// File: rtl/pipe_elastic_stage_if.sv
// Valid/ready handshake, flush and occupancy bundle for pipe_elastic_stage.
// The master side drives the upstream beat, downstream ready and flush; the slave side is the buffer.
interface pipe_elastic_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
);
  logic                       i_Valid_1;
  logic                       o_Ready_1;
  logic [DATA_W-1:0]          i_Data_W;
  logic                       o_Valid_1;
  logic                       i_Ready_1;
  logic [DATA_W-1:0]          o_Data_W;
  logic                       i_Flush_1;
  logic [$clog2(DEPTH+1)-1:0] o_Count_C;
  logic                       o_Full_1;
  logic                       o_Empty_1;

  modport master (
    output i_Valid_1, i_Data_W, i_Ready_1, i_Flush_1,
    input  o_Ready_1, o_Valid_1, o_Data_W, o_Count_C, o_Full_1, o_Empty_1
  );

  modport slave (
    input  i_Valid_1, i_Data_W, i_Ready_1, i_Flush_1,
    output o_Ready_1, o_Valid_1, o_Data_W, o_Count_C, o_Full_1, o_Empty_1
  );
endinterface

// File: rtl/pipe_elastic_stage.sv
// DEPTH-entry elastic valid/ready buffer with synchronous flush and occupancy reporting.
// Optional empty-buffer bypass is enabled by defining PIPE_ELASTIC_BYPASS_EN.
module pipe_elastic_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input logic                 clk,
  input logic                 rstn,
  pipe_elastic_stage_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              full, empty, ready, push, pop;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  // Ready is built from local state only, so no combinational path runs from i_Ready_1.
  assign ready = ~full & ~bus.i_Flush_1;

`ifdef PIPE_ELASTIC_BYPASS_EN
  logic bypass;
  assign bypass        = empty & ~bus.i_Flush_1;
  assign bus.o_Valid_1 = bypass ? bus.i_Valid_1 : ~empty & ~bus.i_Flush_1;
  assign bus.o_Data_W  = bypass ? bus.i_Data_W : mem_q[rp_q];
  // A beat taken straight through an empty buffer is never stored.
  assign push          = bus.i_Valid_1 & ready & ~(bypass & bus.i_Ready_1);
  assign pop           = ~empty & ~bus.i_Flush_1 & bus.i_Ready_1;
`else
  assign bus.o_Valid_1 = ~empty & ~bus.i_Flush_1;
  assign bus.o_Data_W  = mem_q[rp_q];
  assign push          = bus.i_Valid_1 & ready;
  assign pop           = bus.o_Valid_1 & bus.i_Ready_1;
`endif

  assign bus.o_Ready_1 = ready;
  assign bus.o_Count_C = cnt_q;
  assign bus.o_Full_1  = full;
  assign bus.o_Empty_1 = empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (bus.i_Flush_1) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = (wp_q == PtrW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (pop)  rp_d = (rp_q == PtrW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is cleared on reset only; flush leaves stale entries behind the pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= bus.i_Data_W;
    end
  end
endmodule
